seq_uart_tx: RTL and testbench

Host-side serializer: accepts one DEPTH-word sequence in parallel and transmits it on a UART 8N1 line at BAUD, byte by byte, most-significant byte of word 0 first. When the sequence is tagged last, it appends an END_BYTE terminator. It is the transmit counterpart of the uart_rx + rx_buffer receive path, used on-chip as a loopback stimulus source and as an alternative to the tx_buffer + uart_tx output pair.

---
 rtl/seq_uart_tx_if.sv | 24 ++
 rtl/seq_uart_tx.sv | 144 ++++++++++++++
 tb/tb_seq_uart_tx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_uart_tx_if.sv
// Handshake and line signals for the sequence serializer.
// The host drives the master side; seq_uart_tx sits on the slave side.
interface seq_uart_tx_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    logic             valid_in;
    logic             last_in;
    logic [0:WIDTH-1] array_in [0:DEPTH-1];
    logic             ready_out;
    logic             tx;
    logic             busy;
    logic             done;

    modport master (
        output valid_in, last_in, array_in,
        input  ready_out, tx, busy, done
    );

    modport slave (
        input  valid_in, last_in, array_in,
        output ready_out, tx, busy, done
    );
endinterface

// File: rtl/seq_uart_tx.sv
// Serializes one DEPTH-word sequence onto a UART 8N1 line, MSB byte of word 0 first,
// with an optional END_BYTE terminator frame when the sequence is tagged last.
//
// state | meaning
// IDLE  | line high, ready for a new sequence
// START | start bit (0) for the byte in shreg
// DATA  | eight data bits, LSB first
// STOP  | stop bit (1), then next byte, terminator or back to IDLE
module seq_uart_tx #(
    parameter int         CLK_FREQ = 100_000_000,
    parameter int         BAUD     = 115200,
    parameter int         WIDTH    = 32,
    parameter int         DEPTH    = 8,
    parameter logic [7:0] END_BYTE = 8'h0A
) (
    input logic          clk,
    input logic          rst,
    seq_uart_tx_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int NB           = DEPTH * WIDTH / 8;
    localparam int FLAT_W       = NB * 8;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W       = $clog2(NB + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NB - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [2:0]          bit_idx;
    logic [BYTE_W-1:0]   byte_idx;
    logic                term_pending;
    logic [7:0]          shreg;
    logic [FLAT_W-1:0]   seq_q;
    logic [FLAT_W-1:0]   flat_in;
    logic                tx_q;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;

    // Flatten the sequence so the next byte to send is always the top byte.
    always_comb begin
        flat_in = '0;
        for (int k = 0; k < DEPTH; k++) begin
            flat_in[FLAT_W-1-k*WIDTH -: WIDTH] = bus.array_in[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            term_pending <= 1'b0;
            shreg        <= '0;
            seq_q        <= '0;
            tx_q         <= 1'b1;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        seq_q        <= flat_in << 8;
                        shreg        <= flat_in[FLAT_W-1 -: 8];
                        term_pending <= bus.last_in;
                        byte_idx     <= '0;
                        baud_cnt     <= '0;
                        tx_q         <= 1'b0;
                        ready_q      <= 1'b0;
                        busy_q       <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_q     <= shreg[0];
                        shreg    <= shreg >> 1;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            tx_q    <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        // byte_idx parks at NB while the terminator is on the line
                        if (byte_idx < BYTE_LAST) begin
                            byte_idx <= byte_idx + 1'b1;
                            shreg    <= seq_q[FLAT_W-1 -: 8];
                            seq_q    <= seq_q << 8;
                            tx_q     <= 1'b0;
                            state    <= START;
                        end else if (term_pending) begin
                            term_pending <= 1'b0;
                            byte_idx     <= BYTE_W'(NB);
                            shreg        <= END_BYTE;
                            tx_q         <= 1'b0;
                            state        <= START;
                        end else begin
                            byte_idx <= '0;
                            tx_q     <= 1'b1;
                            busy_q   <= 1'b0;
                            ready_q  <= 1'b1;
                            done_q   <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx        = tx_q;
    assign bus.ready_out = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_uart_tx.sv
// Bench for seq_uart_tx: a per-cycle line model (queue of expected tx levels) for an 8x2 instance,
// and a UART receiver model decoding a 32x1 instance.
module tb_seq_uart_tx;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_uart_tx_if #(.WIDTH(8),  .DEPTH(2)) bus_a ();
    seq_uart_tx_if #(.WIDTH(32), .DEPTH(1)) bus_b ();

    seq_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .WIDTH(8), .DEPTH(2), .END_BYTE(8'h0A))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    seq_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .WIDTH(32), .DEPTH(1), .END_BYTE(8'h0A))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   cmp_en = 1'b0;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    bit   line_q[$];
    bit   m_done = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] rx_byte;
    int   frame_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic void push_frame(input logic [7:0] b);
        for (int c = 0; c < CPB; c++) line_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < CPB; c++) line_q.push_back(b[i]);
        for (int c = 0; c < CPB; c++) line_q.push_back(1'b1);
    endfunction

    // Line model: every accepted sequence becomes the list of tx levels, one per cycle.
    always @(posedge clk) begin
        logic [7:0] b;
        cyc = cyc + 1;
        if (rst === 1'b1) begin
            line_q.delete();
            m_done = 1'b0;
        end else if (line_q.size() > 0) begin
            line_q.delete(0);
            m_done = (line_q.size() == 0);
        end else begin
            m_done = 1'b0;
            if (bus_a.valid_in === 1'b1) begin
                acc_cyc = cyc;
                for (int k = 0; k < 2; k++) begin
                    b = bus_a.array_in[k];
                    push_frame(b);
                end
                if (bus_a.last_in === 1'b1) push_frame(8'h0A);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("tx", {31'd0, bus_a.tx}, {31'd0, (line_q.size() > 0) ? line_q[0] : 1'b1});
            check("busy", {31'd0, bus_a.busy}, {31'd0, line_q.size() > 0});
            check("ready_out", {31'd0, bus_a.ready_out}, {31'd0, line_q.size() == 0});
            check("done", {31'd0, bus_a.done}, {31'd0, m_done});
        end
        if (bus_a.busy === 1'b1) busy_cnt++;
        if (bus_a.done === 1'b1) done_cnt++;
    end

    // Receiver model for the 32-bit instance, sampling mid-bit.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_b.tx === 1'b0 && rst !== 1'b1) begin
                repeat (4) @(negedge clk);
                if (bus_b.tx !== 1'b0) frame_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rx_byte[i] = bus_b.tx;
                end
                repeat (CPB) @(negedge clk);
                if (bus_b.tx !== 1'b1) frame_err++;
                rx_q.push_back(rx_byte);
            end
        end
    end

    task automatic send_a(input logic [7:0] b0, input logic [7:0] b1, input logic last);
        @(negedge clk);
        bus_a.array_in[0] = b0;
        bus_a.array_in[1] = b1;
        bus_a.last_in     = last;
        bus_a.valid_in    = 1'b1;
        @(negedge clk);
        bus_a.valid_in    = 1'b0;
    endtask

    task automatic check_line_a(input logic [0:29] pat, input int n);
        for (int i = 0; i < n; i++) begin
            wait (cyc == acc_cyc + CPB * i + CPB / 2);
            @(negedge clk);
            check("line_bit", {31'd0, bus_a.tx}, {31'd0, pat[i]});
        end
    endtask

    task automatic wait_done_a(input int max);
        int n;
        n = 0;
        @(negedge clk);
        while (bus_a.done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", {31'd0, n < max}, 32'd1);
    endtask

    task automatic wait_ready_a(input int max);
        int n;
        n = 0;
        while (bus_a.ready_out !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", {31'd0, n < max}, 32'd1);
    endtask

    logic [0:29] pat_ab = {10'b0101001011, 10'b0001111001, 10'b0010100001};
    logic [7:0]  exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        int n;
        rst = 1'b1;
        bus_a.valid_in = 1'b0; bus_a.last_in = 1'b0;
        bus_a.array_in[0] = '0; bus_a.array_in[1] = '0;
        bus_b.valid_in = 1'b0; bus_b.last_in = 1'b0; bus_b.array_in[0] = '0;

        // Reset held three cycles
        repeat (3) begin
            @(negedge clk);
            cmp_en = 1'b1;
            check("rst_tx", {31'd0, bus_a.tx}, 32'd1);
            check("rst_ready", {31'd0, bus_a.ready_out}, 32'd1);
            check("rst_busy", {31'd0, bus_a.busy}, 32'd0);
            check("rst_done", {31'd0, bus_a.done}, 32'd0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Two bytes, no terminator
        busy_cnt = 0; done_cnt = 0;
        send_a(8'hA5, 8'h3C, 1'b0);
        check_line_a(pat_ab, 20);
        wait_done_a(400);
        @(negedge clk);
        check("busy_len_200", busy_cnt, 32'd200);
        repeat (20) @(negedge clk);
        check("done_once", done_cnt, 32'd1);

        // Same bytes with terminator
        busy_cnt = 0; done_cnt = 0;
        send_a(8'hA5, 8'h3C, 1'b1);
        check_line_a(pat_ab, 30);
        wait_done_a(400);
        @(negedge clk);
        check("busy_len_300", busy_cnt, 32'd300);
        check("done_once_last", done_cnt, 32'd1);

        // 32-bit word decoded MSB byte first
        rx_q.delete();
        @(negedge clk);
        bus_b.array_in[0] = 32'h11223344;
        bus_b.last_in = 1'b0;
        bus_b.valid_in = 1'b1;
        @(negedge clk);
        bus_b.valid_in = 1'b0;
        n = 0;
        while (bus_b.done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("b_done_timeout", {31'd0, n < 1000}, 32'd1);
        repeat (3) @(negedge clk);
        check("b_byte_count", rx_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < rx_q.size(); i++) check("b_byte", {24'd0, rx_q[i]}, {24'd0, exp_b[i]});

        // valid held high with changing data: one sequence, then re-accept right after done
        @(negedge clk);
        bus_a.array_in[0] = 8'($urandom);
        bus_a.array_in[1] = 8'($urandom);
        bus_a.last_in = 1'b0;
        bus_a.valid_in = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            bus_a.array_in[0] = 8'($urandom);
            bus_a.array_in[1] = 8'($urandom);
            n++;
        end while (bus_a.done !== 1'b1 && n < 1000);
        check("hold_done_timeout", {31'd0, n < 1000}, 32'd1);
        @(negedge clk);
        bus_a.valid_in = 1'b0;
        check("reaccept_busy", {31'd0, bus_a.busy}, 32'd1);
        check("reaccept_ready", {31'd0, bus_a.ready_out}, 32'd0);
        wait_done_a(400);

        // Reset during the fourth data bit of byte 0
        repeat (2) @(negedge clk);
        send_a(8'hA5, 8'h3C, 1'b0);
        done_cnt = 0;
        wait (cyc == acc_cyc + 44);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx", {31'd0, bus_a.tx}, 32'd1);
        check("midrst_ready", {31'd0, bus_a.ready_out}, 32'd1);
        check("midrst_busy", {31'd0, bus_a.busy}, 32'd0);
        repeat (300) @(negedge clk);
        check("midrst_no_done", done_cnt, 32'd0);
        send_a(8'hA5, 8'h3C, 1'b0);
        check_line_a(pat_ab, 20);
        wait_done_a(400);

        // Reset and valid in the same cycle
        @(negedge clk);
        rst = 1'b1;
        bus_a.valid_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_a.valid_in = 1'b0;
        check("rstwin_busy", {31'd0, bus_a.busy}, 32'd0);
        check("rstwin_tx", {31'd0, bus_a.tx}, 32'd1);
        repeat (5) @(negedge clk);

        // Randomized sequences with occasional mid-sequence reset
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_a(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 150)) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            wait_ready_a(400);
        end

        repeat (5) @(negedge clk);
        check("rx_framing", frame_err, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
